// File: rtl/mips_pkg.sv
// ------------------------------------------------------------------------
// mips_pkg: shared encodings for the MIPS execute stage (ALU, mul/div, fwd)
// Rev 1.0 - initial release
// ------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_slt = 3'b111;

  localparam logic [2:0] c_md_none  = 3'b000;
  localparam logic [2:0] c_md_mult  = 3'b001;
  localparam logic [2:0] c_md_multu = 3'b010;
  localparam logic [2:0] c_md_div   = 3'b011;
  localparam logic [2:0] c_md_divu  = 3'b100;
  localparam logic [2:0] c_md_mfhi  = 3'b101;
  localparam logic [2:0] c_md_mflo  = 3'b110;

  localparam logic [1:0] c_fwd_reg = 2'b00;
  localparam logic [1:0] c_fwd_wb  = 2'b01;
  localparam logic [1:0] c_fwd_mem = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // True for the ops that occupy the iterative unit (MFHI/MFLO do not).
  function automatic logic is_md_start(input logic [2:0] op);
    return (op == c_md_mult) || (op == c_md_multu) ||
           (op == c_md_div)  || (op == c_md_divu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ------------------------------------------------------------------------
// muldiv_unit: iterative shift-add multiply / restoring divide with HI/LO
// Rev 1.0 - initial release
// ------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_idle,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int c_cw = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;

  md_state_t         r_state;
  md_state_t         w_state_nxt;
  logic [c_cw-1:0]   r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_whi;
  logic [XLEN-1:0]   r_wlo;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_in_signed;
  logic [XLEN-1:0]   w_a_mag_in;
  logic              w_op_signed;
  logic              w_op_div;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_last;
  logic              w_neg;

  logic [XLEN:0]     w_madd;
  logic [XLEN-1:0]   w_mul_hi;
  logic [XLEN-1:0]   w_mul_lo;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic              w_ge;
  logic [XLEN-1:0]   w_div_hi;
  logic [XLEN-1:0]   w_div_lo;
  logic [XLEN-1:0]   w_nxt_hi;
  logic [XLEN-1:0]   w_nxt_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  assign w_in_signed = (i_op == c_md_mult) || (i_op == c_md_div);
  assign w_a_mag_in  = (w_in_signed && i_a[XLEN-1]) ? -i_a : i_a;

  assign w_op_signed = (r_op == c_md_mult) || (r_op == c_md_div);
  assign w_op_div    = (r_op == c_md_div) || (r_op == c_md_divu);
  assign w_b_mag     = (w_op_signed && r_b[XLEN-1]) ? -r_b : r_b;
  assign w_last      = (r_cnt == c_cw'(MD_ITERS - 1));
  assign w_neg       = w_op_signed && (r_a[XLEN-1] ^ r_b[XLEN-1]);

  // Multiply step: {r_whi, r_wlo} is the product/multiplier shift register.
  assign w_madd   = {1'b0, r_whi} + (r_wlo[0] ? {1'b0, w_b_mag} : '0);
  assign w_mul_hi = w_madd[XLEN:1];
  assign w_mul_lo = {w_madd[0], r_wlo[XLEN-1:1]};

  // Divide step: r_whi is the partial remainder, r_wlo shifts dividend out / quotient in.
  assign w_shift  = {r_whi, r_wlo[XLEN-1]};
  assign w_trial  = w_shift - {1'b0, w_b_mag};
  assign w_ge     = ~w_trial[XLEN];
  assign w_div_hi = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_div_lo = {r_wlo[XLEN-2:0], w_ge};

  assign w_nxt_hi = w_op_div ? w_div_hi : w_mul_hi;
  assign w_nxt_lo = w_op_div ? w_div_lo : w_mul_lo;

  assign w_prod     = {w_nxt_hi, w_nxt_lo};
  assign w_prod_fix = w_neg ? -w_prod : w_prod;

  always_comb begin
    w_fix_hi = w_prod_fix[2*XLEN-1:XLEN];
    w_fix_lo = w_prod_fix[XLEN-1:0];
    if (w_op_div) begin
      if (r_b == '0) begin
        w_fix_hi = r_a;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = w_neg ? -w_nxt_lo : w_nxt_lo;
        w_fix_hi = (w_op_signed && r_a[XLEN-1]) ? -w_nxt_hi : w_nxt_hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_idle      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        o_idle = 1'b1;
        if (i_start) w_state_nxt = MD_BUSY;
      end
      MD_BUSY: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = MD_DONE;
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= c_md_none;
      r_a   <= '0;
      r_b   <= '0;
      r_whi <= '0;
      r_wlo <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_op  <= i_op;
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= '0;
            r_whi <= '0;
            r_wlo <= w_a_mag_in;
          end
        end
        MD_BUSY: begin
          r_whi <= w_nxt_hi;
          r_wlo <= w_nxt_lo;
          r_cnt <= r_cnt + c_cw'(1);
          if (w_last) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ------------------------------------------------------------------------
// ex_stage: MIPS EX stage - forwarding, ALU, RegDst mux, mul/div stall
// Rev 1.0 - initial release
// ------------------------------------------------------------------------
`default_nettype none

module ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      EX_E,
  input  logic [2:0]      MD_E,
  input  logic [4:0]      Rt_E,
  input  logic [4:0]      Rd_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] SignImm_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ALUOut_M,
  input  logic [XLEN-1:0] Result_W,
  output logic [XLEN-1:0] ALUOut_E,
  output logic [XLEN-1:0] WriteData_E,
  output logic [4:0]      WriteReg_E,
  output logic            Zero_E,
  output logic            Stall_MD
);

  logic            w_regdst;
  logic            w_alusrc;
  logic [2:0]      w_aluctl;
  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_fwdb;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_alu;
  logic            w_md_start;
  logic            w_md_busy;
  logic            w_md_idle;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;

  assign {w_regdst, w_alusrc, w_aluctl} = EX_E;

  // Select code 11 falls through to the register operand.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] reg_v,
                                              input logic [XLEN-1:0] mem_v,
                                              input logic [XLEN-1:0] wb_v);
    case (sel)
      c_fwd_mem: return mem_v;
      c_fwd_wb:  return wb_v;
      default:   return reg_v;
    endcase
  endfunction

  assign w_srca = fwd_sel(ForwardA_E, RD1_E, ALUOut_M, Result_W);
  assign w_fwdb = fwd_sel(ForwardB_E, RD2_E, ALUOut_M, Result_W);
  assign w_srcb = w_alusrc ? SignImm_E : w_fwdb;

  always_comb begin
    w_alu = '0;
    case (w_aluctl)
      c_alu_add: w_alu = w_srca + w_srcb;
      c_alu_sub: w_alu = w_srca - w_srcb;
      c_alu_and: w_alu = w_srca & w_srcb;
      c_alu_or:  w_alu = w_srca | w_srcb;
      c_alu_slt: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    ALUOut_E = w_alu;
    if (MD_E == c_md_mfhi) begin
      ALUOut_E = w_hi;
    end else if (MD_E == c_md_mflo) begin
      ALUOut_E = w_lo;
    end
  end

  assign WriteData_E = w_fwdb;
  assign WriteReg_E  = w_regdst ? Rd_E : Rt_E;
  assign Zero_E      = (ALUOut_E == '0);

  // Stall drops in DONE even though the op is still in ID/EX, so it is not reissued.
  assign w_md_start = is_md_start(MD_E);
  assign Stall_MD   = (w_md_idle && w_md_start) || w_md_busy;

  muldiv_unit #(
    .XLEN     (XLEN),
    .MD_ITERS (MD_ITERS)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_md_start),
    .i_op    (MD_E),
    .i_a     (w_srca),
    .i_b     (w_srcb),
    .o_busy  (w_md_busy),
    .o_idle  (w_md_idle),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ------------------------------------------------------------------------
// tb_ex_stage: scoreboard bench for ex_stage against a behavioural model
// Rev 1.0 - initial release
// ------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

  localparam int MD_ITERS = 32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  EX_E;
  logic [2:0]  MD_E;
  logic [4:0]  Rt_E, Rd_E;
  logic [31:0] RD1_E, RD2_E, SignImm_E, ALUOut_M, Result_W;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ALUOut_E, WriteData_E;
  logic [4:0]  WriteReg_E;
  logic        Zero_E, Stall_MD;

  ex_stage #(.XLEN(32), .MD_ITERS(MD_ITERS)) dut (
    .clk(clk), .rst_n(rst_n), .EX_E(EX_E), .MD_E(MD_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ALUOut_M(ALUOut_M), .Result_W(Result_W),
    .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E), .WriteReg_E(WriteReg_E),
    .Zero_E(Zero_E), .Stall_MD(Stall_MD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        z;
    logic        st;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: architectural HI/LO plus remaining-stall bookkeeping.
  logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
  int          m_left = 0;
  bit          m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ALUOut_E", ALUOut_E, e.out);
      chk("WriteData_E", WriteData_E, e.wd);
      chk("WriteReg_E", {27'b0, WriteReg_E}, {27'b0, e.wr});
      chk("Zero_E", {31'b0, Zero_E}, {31'b0, e.z});
      chk("Stall_MD", {31'b0, Stall_MD}, {31'b0, e.st});
    end
  end

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'b10) return ALUOut_M;
    if (s == 2'b01) return Result_W;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint      p;
    logic [63:0] ua, ub, up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = '0;
    lo = '0;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
      3'd2: begin up = ua * ub; {hi, lo} = up; end
      3'd3: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      3'd4: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model.
  task automatic tick(input bit check, output bit st);
    logic [31:0] a, bf, b, out;
    bit          start;
    exp_t        e;
    a  = fwd(ForwardA_E, RD1_E);
    bf = fwd(ForwardB_E, RD2_E);
    b  = EX_E[3] ? SignImm_E : bf;
    out = (MD_E == 3'd5) ? m_hi : (MD_E == 3'd6) ? m_lo : alu_ref(EX_E[2:0], a, b);
    start = 0;
    if (m_left > 0)                       st = 1;
    else if (m_done)                      st = 0;
    else if (MD_E >= 3'd1 && MD_E <= 3'd4) begin st = 1; start = 1; end
    else                                  st = 0;
    if (check) begin
      e.out = out; e.wd = bf; e.wr = EX_E[4] ? Rd_E : Rt_E; e.z = (out == 0); e.st = st;
      q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_done = 0;
    end else if (start) begin
      md_ref(MD_E, a, b, m_pend_hi, m_pend_lo);
      m_left = MD_ITERS;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; m_done = 1; end
    end else begin
      m_done = 0;
    end
    #1;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_fields();
    EX_E = 5'($urandom); Rt_E = 5'($urandom); Rd_E = 5'($urandom);
    RD1_E = rv(); RD2_E = rv(); SignImm_E = rv(); ALUOut_M = rv(); Result_W = rv();
    ForwardA_E = 2'($urandom_range(0, 3)); ForwardB_E = 2'($urandom_range(0, 3));
    MD_E = 3'd0;
  endtask

  task automatic step(input bit check);
    bit st;
    tick(check, st);
  endtask

  // Hold the current instruction in ID/EX while the stall is up (bounded).
  task automatic hold_cur();
    bit st;
    for (int i = 0; i < MD_ITERS + 8; i++) begin
      tick(1, st);
      if (!st) break;
    end
  endtask

  task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rand_fields();
    MD_E = op; RD1_E = a; RD2_E = b; ForwardA_E = 2'b00; ForwardB_E = 2'b00; EX_E[3] = 1'b0;
    hold_cur();
  endtask

  task automatic read_hilo();
    rand_fields(); MD_E = 3'd6; step(1);
    rand_fields(); MD_E = 3'd5; step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    rand_fields();
    step(0);
    step(0);
    // Reset state: MFHI/MFLO return 0, no stall.
    rand_fields(); step(1);
    rst_n = 1'b1;
    read_hilo();

    // ALU with forwarding: 7 - 5, then slt(-1, 1).
    rand_fields(); EX_E = 5'b00110; ForwardA_E = 2'b10; ALUOut_M = 32'd7;
    ForwardB_E = 2'b00; RD2_E = 32'd5; step(1);
    rand_fields(); EX_E = 5'b00111; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; step(1);

    md_op(3'd1, 32'hFFFF_FFFF, 32'd2); read_hilo();
    md_op(3'd2, 32'hFFFF_FFFF, 32'd2); read_hilo();
    md_op(3'd3, 32'hFFFF_FFF9, 32'd2); read_hilo();
    md_op(3'd4, 32'd10, 32'd0);        read_hilo();
    md_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); read_hilo();
    md_op(3'd3, 32'hFFFF_FFF0, 32'd0); read_hilo();

    // Reset in the middle of a multiply.
    rand_fields(); MD_E = 3'd1; RD1_E = 32'd3; RD2_E = 32'd4;
    ForwardA_E = 2'b00; ForwardB_E = 2'b00; EX_E[3] = 1'b0;
    for (int i = 0; i < 11; i++) step(1);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1;
    read_hilo();
    md_op(3'd1, 32'd3, 32'd4); read_hilo();

    // Back-to-back: DIVU then MULTU with a single DONE cycle between.
    md_op(3'd4, 32'd9, 32'd4);
    md_op(3'd2, 32'd3, 32'd3);
    read_hilo();

    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 11);
      rand_fields();
      if (r <= 6) begin
        step(1);
      end else if (r == 7) begin
        MD_E = 3'($urandom_range(5, 6)); step(1);
      end else if (r <= 10) begin
        MD_E = 3'($urandom_range(1, 4)); hold_cur(); read_hilo();
      end else begin
        rst_n = 1'b0; step(1); rst_n = 1'b1;
      end
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. Performs operand forwarding, the single-cycle ALU, destination-register selection, and an iterative multiply/divide unit with HI/LO registers. While a MULT/DIV is in flight it raises a stall that freezes the upstream pipeline.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- MD_ITERS, 32, iterations per multiply or divide.

- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- EX_E  in  5  control: [4] RegDst, [3] ALUSrc, [2:0] ALUControl.
- MD_E  in  3  muldiv op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO.
- Rt_E, Rd_E  in  5  candidate destination registers.
- RD1_E, RD2_E  in  32  register-file operands.
- SignImm_E  in  32  sign-extended immediate.
- ForwardA_E, ForwardB_E  in  2  00 register operand, 10 ALUOut_M, 01 Result_W; 11 is treated as 00.
- ALUOut_M  in  32  forwarded value from the MEM stage.
- Result_W  in  32  forwarded value from the WB stage.
- ALUOut_E  out  32  ALU result, or HI/LO for MFHI/MFLO.
- WriteData_E  out  32  forwarded SrcB before the ALUSrc mux (store data).
- WriteReg_E  out  5  Rd_E if RegDst else Rt_E.
- Zero_E  out  1  ALUOut_E == 0.
- Stall_MD  out  1  high: hold PC, IF/ID and ID/EX.

## Operation
- SrcA = forward mux A; SrcB = ALUSrc ? SignImm_E : forward mux B.
- ALUControl: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 0 or 1). Other codes give 0. Add/sub wrap modulo 2^32; no overflow flag.
- MFHI/MFLO override ALUOut_E with HI/LO.
- MULT/MULTU: 64-bit product, HI = upper, LO = lower. Signed ops work on magnitudes, then negate the result if the signs differ.
- DIV/DIVU: restoring divide on magnitudes. LO = quotient, HI = remainder.
  - Signed: quotient is negative if the signs differ; the remainder takes the dividend's sign.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend. It still takes the full MD_ITERS cycles.
  - 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0.
- FSM states:
  - IDLE: if MD_E is a MULT/DIV op, latch SrcA/SrcB (post-forwarding) and the op, clear count, go to BUSY.
  - BUSY: one iteration per cycle. When count == MD_ITERS-1, write HI/LO and go to DONE.
  - DONE: go to IDLE unconditionally.
- Stall_MD = (IDLE && MD_E is MULT/DIV) || BUSY. Stall_MD is low in DONE, so the op leaves ID/EX exactly once and does not reissue.
- ALU, forwarding and WriteReg_E behave the same during a stall. No other EX-side state changes.

## Timing
- ALU path, ALUOut_E, WriteData_E, WriteReg_E, Zero_E: combinational, zero latency.
- MULT/DIV presented in cycle T:
  - Stall_MD is high in cycles T through T+MD_ITERS (33 cycles).
  - The FSM is in DONE at T+33, where Stall_MD is low and the instruction advances.
  - The new HI/LO values are visible from T+33.
  - An MFHI/MFLO immediately following reads the new value.
- Back-to-back MULT/DIV: the second op is seen in IDLE the cycle after DONE and starts normally.
- Reset (rst_n low at a clock edge):
  - FSM goes to IDLE, count = 0, HI = LO = 0, latched operands = 0.
  - Stall_MD is low the following cycle.
  - Reset mid-BUSY aborts the op and leaves HI/LO at 0.
  - Outputs after reset: Stall_MD 0; MFHI/MFLO return 0; the combinational outputs follow the inputs.
- MFHI/MFLO in IDLE: no stall, returns the current HI/LO.

## Structure
- Shared package `mips_pkg`: ALUControl codes, MD op codes, forward-select codes, the md_state_t enum (IDLE/BUSY/DONE).
- Sub-module `muldiv_unit`: holds the FSM, counter, shift registers, sign fix-up and HI/LO.
  - Inputs: start, op, a, b.
  - Outputs: busy, hi, lo.
- `ex_stage` holds the forwarding muxes, the ALU, the RegDst mux and the Stall_MD decode.

## Test plan
- ALU with forwarding:
  - SrcA forwarded from ALUOut_M = 7, SrcB = RD2_E = 5, ALUControl 110 → ALUOut_E = 2, Zero_E = 0.
  - slt with -1, 1 → 1.
- MULT 0xFFFFFFFF × 2 (signed): Stall_MD high for 33 cycles, then MFLO → 0xFFFFFFFE, MFHI → 0xFFFFFFFF. MULTU with the same operands: HI = 1, LO = 0xFFFFFFFE.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 10 / 0 → LO = 0xFFFFFFFF, HI = 10, after the full 33-cycle stall.
- Reset mid-op: MULT 3 × 4, rst_n low at BUSY count 10 → next cycle Stall_MD = 0, MFLO → 0. Then a fresh MULT 3 × 4 → LO = 12.
- Back-to-back ops: DIVU 9 / 4 then MULTU 3 × 3 → two separate 33-cycle stalls with one DONE cycle between them. Final HI/LO = 0/9, and the DIVU result (HI 1, LO 2) is readable in the DONE cycle.
